jt49_dly_sched: RTL and testbench

Time-multiplexed delay-line scheduler that shares one synchronous RAM among the three PSG channels (A, B, C) of JT49's filter section. On each sample strobe it latches the three channel samples and sequences one read and one write per channel into that channel's RAM region. After the last channel it presents all three delayed samples together, each delayed by exactly 2**depth samples. It sits between the channel mixers and the echo/comb filter stages, replacing three independent delay lines with one memory.

---
 rtl/jt49_dly_sched_pkg.sv | 19 +
 rtl/jt49_dly_ram.sv | 24 ++
 rtl/jt49_dly_sched.sv | 144 ++++++++++++++
 tb/tb_jt49_dly_sched.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/jt49_dly_sched_pkg.sv
// Shared definitions for the JT49 delay-line scheduler: FSM state encodings,
// channel count and RAM region-select width.
package jt49_dly_sched_pkg;

  localparam int NCH    = 3;
  localparam int RSEL_W = 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_WR0  = 3'd2,
    S_RD1  = 3'd3,
    S_WR1  = 3'd4,
    S_RD2  = 3'd5,
    S_WR2  = 3'd6,
    S_DONE = 3'd7
  } state_t;

endpackage

// File: rtl/jt49_dly_ram.sv
// Single-port synchronous RAM with registered read data, shared by the three
// delay lines. Read returns the old contents when written in the same cycle.
module jt49_dly_ram #(
  parameter int DW = 8,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Storage write and registered read-first port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/jt49_dly_sched.sv
// Time-multiplexed scheduler: one shared RAM gives each PSG channel a delay of
// exactly 2**depth samples; outputs read 0 until every slot has been written.
module jt49_dly_sched
  import jt49_dly_sched_pkg::*;
#(
  parameter int DW    = 8,
  parameter int depth = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic [DW-1:0] din_a,
  input  logic [DW-1:0] din_b,
  input  logic [DW-1:0] din_c,
  output logic [DW-1:0] dout_a,
  output logic [DW-1:0] dout_b,
  output logic [DW-1:0] dout_c,
  output logic          dout_valid,
  output logic          busy,
  output logic          ovf
);

  localparam int AW = depth + RSEL_W;

  state_t              state_q, state_d;
  logic                start_q;
  logic [depth-1:0]    ptr_q;
  logic                primed_q;
  logic                ovf_q;
  logic                valid_q;
  logic [DW-1:0]       in_q   [NCH];
  logic [DW-1:0]       hold_q [NCH];
  logic [DW-1:0]       dout_q [NCH];

  logic [RSEL_W-1:0]   ch_s;
  logic                wr_s;
  logic                accept_s;
  logic [DW-1:0]       ram_din_s;
  logic [DW-1:0]       ram_dout_s;
  logic [AW-1:0]       ram_addr_s;
  logic                ram_we_s;

  // start_q covers the cycle between accepting cen and entering RD0
  assign accept_s   = cen && (state_q == S_IDLE) && !start_q;
  assign ram_addr_s = {ch_s, ptr_q};
  assign ram_we_s   = wr_s && !rst;

  // Next-state, RAM region select and write strobe
  always_comb begin
    state_d   = state_q;
    ch_s      = 2'd0;
    wr_s      = 1'b0;
    ram_din_s = in_q[0];
    case (state_q)
      S_IDLE: begin
        if (start_q) state_d = S_RD0;
        else         state_d = S_IDLE;
      end
      S_RD0: state_d = S_WR0;
      S_WR0: begin
        wr_s    = 1'b1;
        state_d = S_RD1;
      end
      S_RD1: begin
        ch_s    = 2'd1;
        state_d = S_WR1;
      end
      S_WR1: begin
        ch_s      = 2'd1;
        wr_s      = 1'b1;
        ram_din_s = in_q[1];
        state_d   = S_RD2;
      end
      S_RD2: begin
        ch_s    = 2'd2;
        state_d = S_WR2;
      end
      S_WR2: begin
        ch_s      = 2'd2;
        wr_s      = 1'b1;
        ram_din_s = in_q[2];
        state_d   = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state, sample latches, delayed-sample capture and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      ptr_q    <= '0;
      primed_q <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        in_q[i]   <= '0;
        hold_q[i] <= '0;
        dout_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      start_q <= accept_s;
      valid_q <= (state_q == S_DONE);
      if (cen && !accept_s) ovf_q <= 1'b1;
      if (accept_s) begin
        in_q[0] <= din_a;
        in_q[1] <= din_b;
        in_q[2] <= din_c;
      end
      for (int i = 0; i < NCH; i++) begin
        if (wr_s && (ch_s == i[RSEL_W-1:0])) hold_q[i] <= ram_dout_s;
      end
      if (state_q == S_DONE) begin
        for (int i = 0; i < NCH; i++) begin
          dout_q[i] <= primed_q ? hold_q[i] : '0;
        end
        ptr_q <= ptr_q + 1'b1;
        if (&ptr_q) primed_q <= 1'b1;
      end
    end
  end

  jt49_dly_ram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk  (clk),
    .addr (ram_addr_s),
    .we   (ram_we_s),
    .din  (ram_din_s),
    .dout (ram_dout_s)
  );

  assign dout_a     = dout_q[0];
  assign dout_b     = dout_q[1];
  assign dout_c     = dout_q[2];
  assign dout_valid = valid_q;
  assign busy       = (state_q != S_IDLE);
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_jt49_dly_sched.sv
// Self-checking bench for jt49_dly_sched at depth=2: outputs are compared with
// a history-queue model where output n equals input n-4 (or 0 for n<4).
module tb_jt49_dly_sched;

  logic       clk;
  logic       rst;
  logic       cen;
  logic [7:0] din_a, din_b, din_c;
  logic [7:0] dout_a, dout_b, dout_c;
  logic       dout_valid, busy, ovf;

  int total = 0;
  int bad   = 0;

  logic [7:0] ha[$], hb[$], hc[$];
  int         nsamp;
  logic       ovf_exp;

  jt49_dly_sched #(.DW(8), .depth(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .din_a      (din_a),
    .din_b      (din_b),
    .din_c      (din_c),
    .dout_a     (dout_a),
    .dout_b     (dout_b),
    .dout_c     (dout_c),
    .dout_valid (dout_valid),
    .busy       (busy),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    ha.delete(); hb.delete(); hc.delete();
    nsamp   = 0;
    ovf_exp = 1'b0;
  endtask

  // One legal strobe; intr (1..8) injects an extra cen sampled at that edge
  task automatic run_sample(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input int intr);
    logic [7:0] ea, eb, ec;
    if (nsamp < 4) begin
      ea = 8'd0; eb = 8'd0; ec = 8'd0;
    end else begin
      ea = ha[nsamp-4]; eb = hb[nsamp-4]; ec = hc[nsamp-4];
    end
    ha.push_back(a); hb.push_back(b); hc.push_back(c);
    nsamp++;
    cen = 1'b1; din_a = a; din_b = b; din_c = c;
    tick();
    cen = 1'b0;
    din_a = 8'($urandom); din_b = 8'($urandom); din_c = 8'($urandom);
    for (int k = 1; k <= 9; k++) begin
      if (k == intr) cen = 1'b1;
      tick();
      cen = 1'b0;
      if (k == intr) ovf_exp = 1'b1;
      chk("busy", {31'd0, busy}, {31'd0, (k < 8)});
      chk("dout_valid", {31'd0, dout_valid}, {31'd0, (k == 8)});
      chk("ovf", {31'd0, ovf}, {31'd0, ovf_exp});
      if (k == 8) begin
        chk("dout_a", {24'd0, dout_a}, {24'd0, ea});
        chk("dout_b", {24'd0, dout_b}, {24'd0, eb});
        chk("dout_c", {24'd0, dout_c}, {24'd0, ec});
      end
    end
  endtask

  initial begin
    rst = 1'b1; cen = 1'b0; din_a = 8'd0; din_b = 8'd0; din_c = 8'd0;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_dout_a", {24'd0, dout_a}, 32'd0);
    chk("rst_dout_b", {24'd0, dout_b}, 32'd0);
    chk("rst_dout_c", {24'd0, dout_c}, 32'd0);
    chk("rst_valid", {31'd0, dout_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);

    // priming ramp: outputs 5..8 return samples 1..4
    for (int i = 1; i <= 8; i++) begin
      run_sample(8'(i), 8'(8'h10 + i), 8'(8'h20 + i), 0);
    end

    // random data across several pointer wraps
    for (int i = 0; i < 20; i++) begin
      run_sample(8'($urandom), 8'($urandom), 8'($urandom), 0);
    end

    // strobe coincident with DONE, then a normal strobe
    run_sample(8'($urandom), 8'($urandom), 8'($urandom), 8);
    run_sample(8'($urandom), 8'($urandom), 8'($urandom), 0);

    // reset while the sequencer sits in WR1
    cen = 1'b1; din_a = 8'hA5; din_b = 8'h5A; din_c = 8'hC3;
    tick();
    cen = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    chk("mid_rst_dout_a", {24'd0, dout_a}, 32'd0);
    chk("mid_rst_dout_b", {24'd0, dout_b}, 32'd0);
    chk("mid_rst_dout_c", {24'd0, dout_c}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ovf", {31'd0, ovf}, 32'd0);
    chk("mid_rst_valid", {31'd0, dout_valid}, 32'd0);
    tick();
    chk("mid_rst_idle", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_sample(8'($urandom), 8'($urandom), 8'($urandom), 0);
    end

    // overrun three clocks after a legal strobe, then normal traffic
    run_sample(8'($urandom), 8'($urandom), 8'($urandom), 3);
    for (int i = 0; i < 5; i++) begin
      run_sample(8'($urandom), 8'($urandom), 8'($urandom), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
